axis_rr_arbiter: RTL and testbench
==================================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter AXIS_BYTES, default 1, bytes per tdata beat.
REQ-002 Parameter NUM_SLAVE_STREAMS, default 2, number of input streams; legal range 2..16.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 axis_i_tvalid  input  NUM_SLAVE_STREAMS  per-stream valid; bit n = stream n.
REQ-006 axis_i_tready  output  NUM_SLAVE_STREAMS  per-stream ready.
REQ-007 axis_i_tlast  input  NUM_SLAVE_STREAMS  per-stream end of packet.
REQ-008 axis_i_tdata  input  NUM_SLAVE_STREAMS*AXIS_BYTES*8  packed data; stream n occupies slice n.
REQ-009 axis_o_tvalid / axis_o_tready / axis_o_tlast  output / input / output  1 each  merged master stream.
REQ-010 axis_o_tdata  output  AXIS_BYTES*8  merged data.

Function
REQ-011 The block SHALL merge N slave streams onto one master stream with packet-granular round-robin arbitration; packets are never interleaved.
REQ-012 The FSM SHALL have two states: IDLE (no grant) and LOCKED (grant register holds one stream index).
REQ-013 In IDLE with any axis_i_tvalid high, the next state SHALL be LOCKED with grant = first valid stream searching upward from (last_grant+1) mod N, wrapping.
REQ-014 In IDLE all axis_i_tready and axis_o_tvalid SHALL be 0; arbitration costs exactly one idle cycle per packet.
REQ-015 In LOCKED, axis_o_tvalid/tlast/tdata SHALL equal the granted stream's signals combinationally; axis_i_tready[grant] = axis_o_tready; all other tready bits 0.
REQ-016 In LOCKED, a handshake (axis_o_tvalid & axis_o_tready) with tlast=1 SHALL return the FSM to IDLE and load last_grant = grant.
REQ-017 Handshakes with tlast=0 SHALL not change state; a granted stream dropping tvalid mid-packet SHALL keep the grant (output stalls, no timeout).
REQ-018 A stream deasserting tvalid while requesting in IDLE SHALL not be granted on that cycle's evaluation if its bit is 0 at the clock edge.
REQ-019 With only one stream requesting continuously, it SHALL be re-granted every packet (one bubble between packets).
REQ-020 Data path SHALL add zero latency and hold no data storage; no beat is dropped or duplicated.

Reset
REQ-021 On aresetn low: state = IDLE, grant = 0, last_grant = N-1 (so stream 0 has first priority), all axis_i_tready = 0, axis_o_tvalid = 0, axis_o_tlast = 0.
REQ-022 Reset asserted mid-packet SHALL abort the packet immediately; after release, arbitration restarts from stream 0 priority.
REQ-023 Reset deassertion SHALL be synchronised internally (two-flop) before releasing the FSM.

Configuration
REQ-024 Macro AXIS_RR_ARBITER_GRANT_PORT_EN, when defined, SHALL add output grant_o (width $clog2(NUM_SLAVE_STREAMS)) equal to the grant register and output grant_valid_o high in LOCKED; reset values 0.
REQ-025 Without the macro, those ports SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-026 Shared package axis_arb_pkg SHALL hold the grant-index width function, the FSM state enum (IDLE, LOCKED) and the max-streams constant 16.
REQ-027 One sub-module rr_priority_select SHALL implement the combinational wrap-around first-set search (inputs request vector, last_grant; outputs index, any).

Verification
REQ-028 N=2, reset, stream0 sends 3-beat packet 0x10,0x11,0x12(last) with o_tready=1 -> output beats appear on cycles 2-4 after tvalid, i_tready[1]=0 throughout.
REQ-029 Both streams continuously valid, 1-beat packets (s0=0xA0, s1=0xB0) -> output alternates 0xA0,0xB0,0xA0 with one idle cycle between each.
REQ-030 N=4, streams 1 and 3 valid, last_grant=3 -> grant 1, then 3, then 1.
REQ-031 Granted stream drops tvalid for 5 cycles mid-packet while stream1 valid -> o_tvalid 0 for 5 cycles, grant unchanged, packet completes before stream1 served.
REQ-032 o_tready toggled randomly 50% over 100 packets -> output byte sequence per stream identical to input, no interleaving.
REQ-033 aresetn pulsed low during beat 2 of 4 -> all outputs 0 asynchronously; after release stream 0 wins next arbitration.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the packet-granular AXI-Stream round-robin arbiter:
// stream limit, FSM state encoding and grant index width helper.
package axis_arb_pkg;

  localparam int MAX_STREAMS = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // A one-bit index is kept even for degenerate sizes so ports never collapse to zero width.
  function automatic int grant_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational wrap-around first-set search: finds the first asserted request
// starting one position above last_grant and wrapping back to index 0.
module rr_priority_select
  import axis_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = grant_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] idx,
  output logic         any
);

  // Candidates are visited in priority order, so the first hit wins and later ones are ignored.
  always_comb begin
    int cand;
    cand = 0;
    idx  = '0;
    any  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N) cand = cand - N;
      if (cand >= N) cand = cand - N;
      if (!any && (cand < N) && req[cand]) begin
        idx = W'(cand);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Merges NUM_SLAVE_STREAMS AXI-Stream inputs onto one output, one whole packet at a time,
// round-robin. Define AXIS_RR_ARBITER_GRANT_PORT_EN to expose grant_o / grant_valid_o.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int AXIS_BYTES        = 1,
  parameter int NUM_SLAVE_STREAMS = 2
) (
  input  logic                                    clk,
  input  logic                                    aresetn,
  input  logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tvalid,
  output logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tready,
  input  logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tlast,
  input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
  output logic                                    axis_o_tvalid,
  input  logic                                    axis_o_tready,
  output logic                                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]                 axis_o_tdata
`ifdef AXIS_RR_ARBITER_GRANT_PORT_EN
  ,
  output logic [grant_width(NUM_SLAVE_STREAMS)-1:0] grant_o,
  output logic                                    grant_valid_o
`endif
);

  localparam int N  = NUM_SLAVE_STREAMS;
  localparam int W  = grant_width(N);
  localparam int DW = AXIS_BYTES * 8;
  localparam logic [W-1:0] LAST_INIT = W'(N - 1);

  logic [1:0]   rst_sync;
  logic         rst_n;
  arb_state_e   state, state_nxt;
  logic [W-1:0] grant, grant_nxt;
  logic [W-1:0] last_grant, last_grant_nxt;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         locked;
  logic         sel_tvalid;
  logic         sel_tlast;
  logic [DW-1:0] sel_tdata;
  logic         handshake;

  // Assertion is immediate; release is delayed two clocks so the FSM never sees a ragged edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_INIT;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  rr_priority_select #(
    .N (N),
    .W (W)
  ) u_select (
    .req        (axis_i_tvalid),
    .last_grant (last_grant),
    .idx        (sel_idx),
    .any        (sel_any)
  );

  assign locked = (state == LOCKED);

  // Pure combinational steering: the granted stream is wired straight through, nothing is stored.
  always_comb begin
    sel_tvalid    = 1'b0;
    sel_tlast     = 1'b0;
    sel_tdata     = '0;
    axis_i_tready = '0;
    for (int n = 0; n < N; n++) begin
      if (grant == W'(n)) begin
        sel_tvalid       = axis_i_tvalid[n];
        sel_tlast        = axis_i_tlast[n];
        sel_tdata        = axis_i_tdata[n*DW +: DW];
        axis_i_tready[n] = locked & axis_o_tready;
      end
    end
  end

  assign axis_o_tvalid = locked & sel_tvalid;
  assign axis_o_tlast  = locked & sel_tlast;
  assign axis_o_tdata  = locked ? sel_tdata : '0;
  assign handshake     = axis_o_tvalid & axis_o_tready;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (sel_any) begin
          state_nxt = LOCKED;
          grant_nxt = sel_idx;
        end
      end
      LOCKED: begin
        // Only the closing beat releases the grant; stalls and gaps keep the packet owner.
        if (handshake && axis_o_tlast) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AXIS_RR_ARBITER_GRANT_PORT_EN
  assign grant_o       = grant;
  assign grant_valid_o = locked;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter (4 streams, 1 byte): directed scenarios plus a
// randomized run, checked against a packet-level round-robin reference model.
module tb_axis_rr_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [N-1:0] i_tvalid, i_tready, i_tlast;
  logic [N*8-1:0] i_tdata;
  logic         o_tvalid, o_tready, o_tlast;
  logic [7:0]   o_tdata;
`ifdef AXIS_RR_ARBITER_GRANT_PORT_EN
  logic [1:0]   grant_o;
  logic         grant_valid_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] pkt_q   [N][$];
  logic [7:0] exp_all [N][$];
  logic [7:0] rcv     [N][$];
  logic [7:0] out_seq [$];
  int         owner;
  int         last_g;
  int         cycles;

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .AXIS_BYTES        (1),
    .NUM_SLAVE_STREAMS (N)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .axis_i_tvalid (i_tvalid),
    .axis_i_tready (i_tready),
    .axis_i_tlast  (i_tlast),
    .axis_i_tdata  (i_tdata),
    .axis_o_tvalid (o_tvalid),
    .axis_o_tready (o_tready),
    .axis_o_tlast  (o_tlast),
    .axis_o_tdata  (o_tdata)
`ifdef AXIS_RR_ARBITER_GRANT_PORT_EN
    ,
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit allEmpty();
    bit e;
    e = (owner < 0);
    for (int n = 0; n < N; n++) if (pkt_q[n].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic pushPkt(input int s, input int len, input logic [7:0] base);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i);
      pkt_q[s].push_back({(i == len - 1), b});
      exp_all[s].push_back(b);
    end
  endtask

  task automatic modelReset();
    owner  = -1;
    last_g = N - 1;
    out_seq.delete();
    for (int n = 0; n < N; n++) begin
      pkt_q[n].delete();
      exp_all[n].delete();
      rcv[n].delete();
    end
  endtask

  task automatic doReset();
    aresetn  = 1'b0;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    o_tready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("rst_i_tready", 32'(i_tready), 32'd0);
    checkOutput("rst_o_tlast", 32'(o_tlast), 32'd0);
    aresetn = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // One clock of stimulus: drive sources from their packet queues, check the merged
  // outputs against the model, then let the model take its decision for the coming edge.
  task automatic applyStimulus(input logic [N-1:0] en, input logic ordy);
    logic [N-1:0] vld;
    logic [N-1:0] exp_rdy;
    logic         exp_tv, exp_tl;
    logic [7:0]   exp_td;
    int           s;
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) begin
      vld[n] = en[n] && (pkt_q[n].size() > 0);
      i_tdata[n*8 +: 8] = vld[n] ? pkt_q[n][0][7:0] : 8'h00;
      i_tlast[n]        = vld[n] ? pkt_q[n][0][8] : 1'b0;
    end
    i_tvalid = vld;
    o_tready = ordy;
    #1;
    exp_tv  = 1'b0;
    exp_tl  = 1'b0;
    exp_td  = 8'h00;
    exp_rdy = '0;
    if (owner >= 0) begin
      exp_tv         = vld[owner];
      exp_rdy[owner] = ordy;
      if (exp_tv) begin
        exp_td = pkt_q[owner][0][7:0];
        exp_tl = pkt_q[owner][0][8];
      end
    end
    checkOutput("o_tvalid", 32'(o_tvalid), 32'(exp_tv));
    checkOutput("i_tready", 32'(i_tready), 32'(exp_rdy));
    checkOutput("o_tlast", 32'(o_tlast), 32'(exp_tl));
    if (exp_tv) checkOutput("o_tdata", 32'(o_tdata), 32'(exp_td));
`ifdef AXIS_RR_ARBITER_GRANT_PORT_EN
    checkOutput("grant_valid_o", 32'(grant_valid_o), 32'(owner >= 0));
    if (owner >= 0) checkOutput("grant_o", 32'(grant_o), 32'(owner));
`endif
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        s = (last_g + k) % N;
        if (owner < 0 && vld[s]) owner = s;
      end
    end else if (exp_tv && ordy) begin
      rcv[owner].push_back(o_tdata);
      out_seq.push_back(o_tdata);
      void'(pkt_q[owner].pop_front());
      if (exp_tl) begin
        last_g = owner;
        owner  = -1;
      end
    end
  endtask

  task automatic drainQueues(input logic [N-1:0] en, input bit rnd, input int bound, output int cyc);
    logic [N-1:0] m;
    cyc = 0;
    while (!allEmpty() && cyc < bound) begin
      if (rnd) begin
        m = en & (N'($urandom) | N'($urandom));
        applyStimulus(m, 1'($urandom));
      end else begin
        applyStimulus(en, 1'b1);
      end
      cyc++;
    end
    checkOutput("drain_done", 32'(allEmpty()), 32'd1);
  endtask

  task automatic checkSeq(input string tag, input int cnt, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    checkOutput({tag, "_len"}, 32'(out_seq.size()), 32'(cnt));
    for (int i = 0; i < cnt; i++)
      if (i < out_seq.size()) checkOutput({tag, "_byte"}, 32'(out_seq[i]), 32'(e[i]));
  endtask

  initial begin
    aresetn  = 1'b0;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    o_tready = 1'b0;
    modelReset();

    // Single 3-beat packet on stream 0: one arbitration cycle then three beats.
    doReset();
    pushPkt(0, 3, 8'h10);
    drainQueues(4'b0001, 1'b0, 50, cycles);
    checkOutput("pktA_cycles", 32'(cycles), 32'd4);
    checkSeq("pktA", 3, 8'h10, 8'h11, 8'h12, 8'h00);

    // Two streams always valid with 1-beat packets alternate with a bubble each.
    doReset();
    pushPkt(0, 1, 8'hA0); pushPkt(1, 1, 8'hB0);
    pushPkt(0, 1, 8'hA0); pushPkt(1, 1, 8'hB0);
    drainQueues(4'b0011, 1'b0, 50, cycles);
    checkOutput("alt_cycles", 32'(cycles), 32'd8);
    checkSeq("alt", 4, 8'hA0, 8'hB0, 8'hA0, 8'hB0);

    // Streams 1 and 3 only, starting from last_grant = 3.
    doReset();
    pushPkt(1, 1, 8'h51); pushPkt(3, 1, 8'h71);
    pushPkt(1, 1, 8'h52); pushPkt(3, 1, 8'h72);
    drainQueues(4'b1010, 1'b0, 50, cycles);
    checkSeq("skip", 4, 8'h51, 8'h71, 8'h52, 8'h72);

    // Granted stream goes quiet for five cycles mid-packet; stream 1 must wait.
    doReset();
    pushPkt(0, 3, 8'h20);
    pushPkt(1, 1, 8'h30);
    applyStimulus(4'b0011, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0010, 1'b1);
      checkOutput("stall_o_tvalid", 32'(o_tvalid), 32'd0);
      checkOutput("stall_tready1", 32'(i_tready[1]), 32'd0);
    end
    drainQueues(4'b0011, 1'b0, 50, cycles);
    checkSeq("stall", 4, 8'h20, 8'h21, 8'h22, 8'h30);

    // Reset mid-packet kills outputs at once; stream 0 regains first priority afterwards.
    doReset();
    pushPkt(0, 4, 8'h40);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("abort_o_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("abort_i_tready", 32'(i_tready), 32'd0);
    checkOutput("abort_o_tlast", 32'(o_tlast), 32'd0);
    doReset();
    pushPkt(2, 1, 8'h62);
    pushPkt(0, 1, 8'h42);
    drainQueues(4'b0101, 1'b0, 50, cycles);
    checkSeq("post_rst", 2, 8'h42, 8'h62, 8'h00, 8'h00);

    // 100 random packets with random source gaps and 50% output backpressure.
    doReset();
    for (int p = 0; p < 100; p++)
      pushPkt($urandom_range(0, N - 1), $urandom_range(1, 4), 8'($urandom));
    drainQueues(4'b1111, 1'b1, 5000, cycles);
    for (int n = 0; n < N; n++) begin
      checkOutput("rand_count", 32'(rcv[n].size()), 32'(exp_all[n].size()));
      for (int i = 0; i < exp_all[n].size(); i++)
        if (i < rcv[n].size()) checkOutput("rand_data", 32'(rcv[n][i]), 32'(exp_all[n][i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
